// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM state type and default widths/limits for the pipeline hazard controller
package pipe_pkg;
  localparam int REG_AW = 5;
  localparam int MEM_TIMEOUT = 16;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare; ports rs1_i/rs2_i/use_rs1_i/use_rs2_i (ID), rd_i/mem_read_i (EX), luh_o
module hazard_detect #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          use_rs1_i,
  input  logic          use_rs2_i,
  input  logic [AW-1:0] rd_i,
  input  logic          mem_read_i,
  output logic          luh_o
);
  assign luh_o = mem_read_i & (rd_i != '0) & ((use_rs1_i & (rs1_i == rd_i)) | (use_rs2_i & (rs2_i == rd_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/mem-wait stall+flush control with timeout watchdog; inputs ID rs/use, EX rd/load/branch, MEM access/ready; outputs stalls, flushes, mem_err, state; HAZ_PERF_EN adds perf_* counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = pipe_pkg::MEM_TIMEOUT,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              stall_ex_mem,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              mem_err,
`ifdef HAZ_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_luh_cnt,
`endif
  output logic [1:0]        state
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic luh, stall, fl_if, fl_idex, luh_fire;
  hazard_detect #(.AW(REG_AW)) u_hd (
    .rs1_i(id_rs1), .rs2_i(id_rs2), .use_rs1_i(id_use_rs1), .use_rs2_i(id_use_rs2),
    .rd_i(ex_rd), .mem_read_i(ex_mem_read), .luh_o(luh)
  );
  always_comb begin
    stall = 1'b0;
    fl_if = 1'b0;
    fl_idex = 1'b0;
    luh_fire = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ERR) stall = 1'b1;
    else if (state_q == RUN && mem_access && !mem_ready) begin
      stall = 1'b1;
      state_d = MEM_WAIT;
      cnt_d = CNT_W'(1);
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      stall = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = ERR;
        err_d = 1'b1;
      end
    end else if (state_q == RUN || state_q == MEM_WAIT) begin
      // a taken branch flushes the dependent instruction, so it overrides the load-use stall
      state_d = RUN;
      cnt_d = '0;
      fl_if = ex_br_taken;
      fl_idex = ex_br_taken | luh;
      luh_fire = !ex_br_taken & luh;
    end else state_d = RUN;
  end
  assign stall_pc = !reset & (stall | luh_fire);
  assign stall_if_id = !reset & (stall | luh_fire);
  assign stall_id_ex = !reset & stall;
  assign stall_ex_mem = !reset & stall;
  assign flush_if_id = !reset & fl_if;
  assign flush_id_ex = !reset & fl_idex;
  assign mem_err = !reset & err_q;
  assign state = reset ? RUN : state_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_luh_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(stall_ex_mem && perf_stall_cnt != '1);
      perf_flush_cnt <= perf_flush_cnt + 32'(flush_if_id && perf_flush_cnt != '1);
      perf_luh_cnt <= perf_luh_cnt + 32'(luh_fire && perf_luh_cnt != '1);
    end
  end
`endif
endmodule
